mem_access_ctrl: RTL

- MEM-stage access controller on the consuming side of the EX/MEM pipeline register.
- Inputs: the registered MemRead/MemWrite controls, the ALU result (used as the address) and the RS2 store data.
- Runs a req/ack transaction with a variable-latency data memory and holds the pipeline via stall_o until the access completes.
- Presents load data to the MEM/WB register.

---
 rtl/mem_access_ctrl_if.sv | 43 ++++
 rtl/mem_access_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl_if.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl_if
// Request/acknowledge bus between the MEM-stage access controller and the
// variable-latency data memory.
//
// Signals:
//   mem_req_o    controller -> memory  request, held until completion
//   mem_we_o     controller -> memory  1 = write, 0 = read
//   mem_addr_o   controller -> memory  word-aligned byte address
//   mem_wdata_o  controller -> memory  store data
//   mem_ack_i    memory -> controller  single-cycle completion pulse
//   mem_rdata_i  memory -> controller  load data, valid with mem_ack_i
//
// Modports:
//   master  the access controller
//   slave   the data memory
// ---------------------------------------------------------------------------
interface mem_access_ctrl_if;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;

    modport master (
        output mem_req_o,
        output mem_we_o,
        output mem_addr_o,
        output mem_wdata_o,
        input  mem_ack_i,
        input  mem_rdata_i
    );

    modport slave (
        input  mem_req_o,
        input  mem_we_o,
        input  mem_addr_o,
        input  mem_wdata_o,
        output mem_ack_i,
        output mem_rdata_i
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl
// MEM-stage access controller sitting after the EX/MEM pipeline register.
// Turns a registered load/store request into a req/ack transaction with a
// variable-latency data memory, freezes the pipeline through stall_o while
// the access is outstanding, and hands load data to the MEM/WB register.
//
// Optional feature macro: MEM_TIMEOUT_EN
//   defined   - a BUSY-cycle counter aborts an access that is not acked
//               within TIMEOUT_CYCLES cycles and pulses timeout_o
//   undefined - BUSY waits for the ack indefinitely, timeout_o is tied 0
//
// Parameters:
//   TIMEOUT_CYCLES  maximum BUSY cycles before abort (MEM_TIMEOUT_EN only)
//
// Ports:
//   clk_i          clock
//   rst_i          asynchronous active-high reset
//   MemRead_i      load request from EX/MEM
//   MemWrite_i     store request from EX/MEM (wins over MemRead_i)
//   addr_i         byte address (ALU result) from EX/MEM
//   wdata_i        store data (RS2) from EX/MEM
//   stall_o        combinational pipeline freeze
//   rdata_o        load data to MEM/WB, held until the next load completes
//   rdata_valid_o  one-cycle pulse when rdata_o carries new load data
//   misalign_o     one-cycle pulse when an access is dropped as misaligned
//   timeout_o      one-cycle pulse when an access is aborted
//   mem            memory bus, master side
// ---------------------------------------------------------------------------
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic [31:0]       addr_i,
    input  logic [31:0]       wdata_i,
    output logic              stall_o,
    output logic [31:0]       rdata_o,
    output logic              rdata_valid_o,
    output logic              misalign_o,
    output logic              timeout_o,
    mem_access_ctrl_if.master mem
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic acc;
    logic aligned;
    logic start_acc;
    logic drop_acc;
    logic ack_done;
    logic abort_acc;
    logic cnt_expired;

    // A zero limit would leave the counter compare meaningless.
    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("mem_access_ctrl: TIMEOUT_CYCLES must be at least 1");
    end

    assign acc     = MemRead_i | MemWrite_i;
    assign aligned = (addr_i[1:0] == 2'b00);

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] busy_cnt;

    // busy_cnt holds the index of the current BUSY cycle (0 in the first one),
    // so the last allowed cycle is TIMEOUT_CYCLES-1.
    assign cnt_expired = (busy_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_cnt  <= '0;
            timeout_o <= 1'b0;
        end else begin
            timeout_o <= abort_acc;
            if (start_acc) begin
                busy_cnt <= '0;
            end else if (state_q == BUSY) begin
                busy_cnt <= busy_cnt + 1'b1;
            end
        end
    end
`else
    assign cnt_expired = 1'b0;
    assign timeout_o   = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and stall. stall_o rises in the detect cycle itself so the
    // pipeline never advances past an access that is about to start.
    // An ack takes priority over an expiring counter in the same cycle.
    always_comb begin
        state_d   = state_q;
        stall_o   = 1'b0;
        start_acc = 1'b0;
        drop_acc  = 1'b0;
        ack_done  = 1'b0;
        abort_acc = 1'b0;
        case (state_q)
            IDLE: begin
                if (acc) begin
                    if (aligned) begin
                        stall_o   = 1'b1;
                        start_acc = 1'b1;
                        state_d   = BUSY;
                    end else begin
                        drop_acc = 1'b1;
                    end
                end
            end
            BUSY: begin
                stall_o = 1'b1;
                if (mem.mem_ack_i) begin
                    ack_done = 1'b1;
                    state_d  = DONE;
                end else if (cnt_expired) begin
                    abort_acc = 1'b1;
                    state_d   = DONE;
                end
            end
            // DONE lets the pipeline advance and never starts an access, so
            // the EX/MEM contents still present this cycle are not replayed.
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Registered bus and result outputs. Request fields are captured once
    // at start and stay frozen for the whole BUSY period.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem.mem_req_o   <= 1'b0;
            mem.mem_we_o    <= 1'b0;
            mem.mem_addr_o  <= 32'h0;
            mem.mem_wdata_o <= 32'h0;
            rdata_o         <= 32'h0;
            rdata_valid_o   <= 1'b0;
            misalign_o      <= 1'b0;
        end else begin
            rdata_valid_o <= 1'b0;
            misalign_o    <= 1'b0;
            if (start_acc) begin
                mem.mem_req_o   <= 1'b1;
                mem.mem_we_o    <= MemWrite_i;
                mem.mem_addr_o  <= {addr_i[31:2], 2'b00};
                mem.mem_wdata_o <= wdata_i;
            end
            if (drop_acc) begin
                misalign_o <= 1'b1;
            end
            if (ack_done) begin
                mem.mem_req_o <= 1'b0;
                if (!mem.mem_we_o) begin
                    rdata_o       <= mem.mem_rdata_i;
                    rdata_valid_o <= 1'b1;
                end
            end
            if (abort_acc) begin
                mem.mem_req_o <= 1'b0;
            end
        end
    end

endmodule
